// File: rtl/exec_pkg.sv
// Slot types and helpers for the immediate execute/writeback pipeline.
`include "processor_defines.sv"

package exec_pkg;

    localparam int EXEC_XLEN = 32;
    localparam int REG_COUNT = 32;

    // Operand-latch slot: everything the ALU needs, captured at the input handshake
    typedef struct packed {
        logic [4:0]           rd;
        logic [11:0]          imm;
        logic [4:0]           alu_control;
        logic [EXEC_XLEN-1:0] op1;
    } a_slot_t;

    // Result slot: what is presented to the consumer
    typedef struct packed {
        logic [4:0]           rd;
        logic [EXEC_XLEN-1:0] result;
        logic                 illegal;
    } b_slot_t;

    function automatic logic [EXEC_XLEN-1:0] sign_extend_imm(input logic [11:0] imm);
        return {{(EXEC_XLEN-12){imm[11]}}, imm};
    endfunction

endpackage

// File: rtl/processor_defines.sv
// Shared ALU operation codes for the I-type decoder and its downstream stages.
`ifndef FILE_INCL
`define FILE_INCL

`define ALU_NOP 5'b00000
`define ADDI    5'b00001
`define SLTI    5'b00010
`define SLTIU   5'b00011
`define XORI    5'b00100
`define ORI     5'b00101
`define ANDI    5'b00110
`define SLLI    5'b00111
`define SRLI    5'b01000
`define SRAI    5'b01001

`endif

// File: rtl/reg_file.sv
// 32-entry register file: one write port, two combinational read ports, x0 hardwired to zero.
module reg_file
    import exec_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 we,
    input  logic [4:0]           waddr,
    input  logic [EXEC_XLEN-1:0] wdata,
    input  logic [4:0]           raddr_a,
    output logic [EXEC_XLEN-1:0] rdata_a,
    input  logic [4:0]           raddr_b,
    output logic [EXEC_XLEN-1:0] rdata_b
);

    logic [EXEC_XLEN-1:0] regs [REG_COUNT];

    // Storage clears on reset; writes aimed at x0 are dropped so it always holds zero
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (waddr != 5'd0)) begin
            regs[waddr] <= wdata;
        end
    end

    // Both read ports are plain lookups with x0 forced to zero
    always_comb begin
        rdata_a = (raddr_a == 5'd0) ? '0 : regs[raddr_a];
        rdata_b = (raddr_b == 5'd0) ? '0 : regs[raddr_b];
    end

endmodule

// File: rtl/imm_execute_stage.sv
// Two-stage immediate-ALU execute/writeback pipeline with A-stage forwarding.
module imm_execute_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      in_rs1,
    input  logic [4:0]      in_rd,
    input  logic [11:0]     in_imm,
    input  logic [4:0]      in_alu_control,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [4:0]      out_rd,
    output logic [XLEN-1:0] out_result,
    output logic            out_illegal,
    output logic [31:0]     retired_count,
    input  logic [4:0]      dbg_raddr,
    output logic [XLEN-1:0] dbg_rdata
);

    import exec_pkg::*;

    a_slot_t        a_slot;
    b_slot_t        b_slot;
    logic           a_valid;
    logic           b_free;
    logic           a_adv;
    logic           in_fire;
    logic           out_fire;
    logic [XLEN-1:0] simm;
    logic [4:0]      shamt;
    logic [XLEN-1:0] alu_result;
    logic            alu_illegal;
    logic [XLEN-1:0] rf_rdata;
    logic [XLEN-1:0] op1_next;
    logic            rf_we;

    // Handshake plumbing: A can move whenever B is empty or draining this cycle
    always_comb begin
        b_free   = !out_valid || out_ready;
        a_adv    = a_valid && b_free;
        in_ready = !a_valid || a_adv;
        in_fire  = in_valid && in_ready;
        out_fire = out_valid && out_ready;
    end

    // Immediate ALU evaluated on the A slot; unknown codes and NOP flag illegal with a zero result
    always_comb begin
        simm        = sign_extend_imm(a_slot.imm);
        shamt       = a_slot.imm[4:0];
        alu_result  = '0;
        alu_illegal = 1'b0;
        case (a_slot.alu_control)
            `ADDI:   alu_result = a_slot.op1 + simm;
            `SLTI:   alu_result = {{(XLEN-1){1'b0}}, ($signed(a_slot.op1) < $signed(simm))};
            `SLTIU:  alu_result = {{(XLEN-1){1'b0}}, (a_slot.op1 < simm)};
            `XORI:   alu_result = a_slot.op1 ^ simm;
            `ORI:    alu_result = a_slot.op1 | simm;
            `ANDI:   alu_result = a_slot.op1 & simm;
            `SLLI:   alu_result = a_slot.op1 << shamt;
            `SRLI:   alu_result = a_slot.op1 >> shamt;
            `SRAI:   alu_result = $unsigned($signed(a_slot.op1) >>> shamt);
            default: alu_illegal = 1'b1;
        endcase
    end

    // Operand select: the regfile write from A lands on the same edge, so bypass it directly
    always_comb begin
        op1_next = rf_rdata;
        if (in_rs1 == 5'd0) begin
            op1_next = '0;
        end else if (a_adv && !alu_illegal && (a_slot.rd == in_rs1) && (a_slot.rd != 5'd0)) begin
            op1_next = alu_result;
        end
    end

    // Writeback happens as the result moves into B; illegal slots and x0 never write
    always_comb begin
        rf_we = a_adv && !alu_illegal && (a_slot.rd != 5'd0);
    end

    reg_file u_reg_file (
        .clk     (clk),
        .reset_n (reset_n),
        .we      (rf_we),
        .waddr   (a_slot.rd),
        .wdata   (alu_result),
        .raddr_a (in_rs1),
        .rdata_a (rf_rdata),
        .raddr_b (dbg_raddr),
        .rdata_b (dbg_rdata)
    );

    // A slot: fills on an input handshake, empties when it advances with nothing behind it
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_valid <= 1'b0;
            a_slot  <= '0;
        end else if (in_fire) begin
            a_valid            <= 1'b1;
            a_slot.rd          <= in_rd;
            a_slot.imm         <= in_imm;
            a_slot.alu_control <= in_alu_control;
            a_slot.op1         <= op1_next;
        end else if (a_adv) begin
            a_valid <= 1'b0;
        end
    end

    // B slot: takes the ALU result when A advances, empties on a handshake with no replacement
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            b_slot    <= '0;
        end else if (a_adv) begin
            out_valid      <= 1'b1;
            b_slot.rd      <= a_slot.rd;
            b_slot.result  <= alu_result;
            b_slot.illegal <= alu_illegal;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Count of results actually taken by the consumer, wrapping naturally
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            retired_count <= '0;
        end else if (out_fire) begin
            retired_count <= retired_count + 32'd1;
        end
    end

    assign out_rd      = b_slot.rd;
    assign out_result  = b_slot.result;
    assign out_illegal = b_slot.illegal;

endmodule
